// File: rtl/btb_pkg.sv
// btb_pkg: counter type, counter encodings and address-split width helpers
// shared by the branch target buffer and its counter logic.
`default_nettype none

package btb_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT  = 2'b00;
  localparam cnt_t CNT_WNT  = 2'b01;
  localparam cnt_t CNT_WT   = 2'b10;
  localparam cnt_t CNT_ST   = 2'b11;
  localparam cnt_t CNT_INIT = CNT_WT;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Word-aligned addresses: bits [1:0] never reach index or tag.
  function automatic int tag_w(input int xlen, input int sets);
    return xlen - $clog2(sets) - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_sat_counter.sv
// btb_sat_counter: 2-bit saturating up/down next-state logic.
`default_nettype none

module btb_sat_counter
  import btb_pkg::*;
(
  input  cnt_t cnt,
  input  logic taken,
  output cnt_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with combinational lookup,
// 2-bit direction counters and per-set round-robin replacement.
`default_nettype none

module btb_assoc
  import btb_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            update,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  input  logic            flush,
  output logic [XLEN-1:0] target_pc,
  output logic            valid,
  output logic            predictedTaken
);

  localparam int IDX = idx_w(SETS);
  localparam int TW  = tag_w(XLEN, SETS);
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic            r_valid [SETS][WAYS];
  logic [TW-1:0]   r_tag   [SETS][WAYS];
  logic [XLEN-1:0] r_tgt   [SETS][WAYS];
  cnt_t            r_cnt   [SETS][WAYS];

  logic [IDX-1:0]  w_idx, w_uidx;
  logic [TW-1:0]   w_tag, w_utag;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_tgt;
  cnt_t            w_hit_cnt;
  logic            w_uhit, w_has_inv, w_alloc, w_repl;
  logic [WW-1:0]   w_uway, w_inv_way, w_rr_way, w_alloc_way;
  cnt_t            w_cnt_next;

  assign w_idx  = pc[IDX+1:2];
  assign w_tag  = pc[XLEN-1:IDX+2];
  assign w_uidx = update_pc[IDX+1:2];
  assign w_utag = update_pc[XLEN-1:IDX+2];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_tgt = '0;
    w_hit_cnt = CNT_SNT;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_tgt = r_tgt[w_idx][w];
        w_hit_cnt = r_cnt[w_idx][w];
      end
    end
  end

  assign valid          = w_hit;
  assign predictedTaken = w_hit & w_hit_cnt[1];
  assign target_pc      = w_hit ? w_hit_tgt : pc + XLEN'(4);

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_uhit    = 1'b0;
    w_uway    = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_uidx][w] && r_tag[w_uidx][w] == w_utag) begin
        w_uhit = 1'b1;
        w_uway = WW'(w);
      end
      if (!r_valid[w_uidx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WW'(w);
      end
    end
  end

  assign w_alloc     = update & ~w_uhit & update_taken;
  assign w_repl      = w_alloc & ~w_has_inv;
  assign w_alloc_way = w_has_inv ? w_inv_way : w_rr_way;

  btb_sat_counter u_cnt (
    .cnt      (r_cnt[w_uidx][w_uway]),
    .taken    (update_taken),
    .cnt_next (w_cnt_next)
  );

  generate
    if (WAYS > 1) begin : g_rr
      logic [WW-1:0] r_ptr [SETS];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (flush) begin
          for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (w_repl) begin
          r_ptr[w_uidx] <= r_ptr[w_uidx] + WW'(1);
        end
      end
      assign w_rr_way = r_ptr[w_uidx];
    end else begin : g_no_rr
      assign w_rr_way = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_tgt[s][w]   <= '0;
          r_cnt[s][w]   <= CNT_WNT;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
      end
    end else if (update && w_uhit) begin
      r_tgt[w_uidx][w_uway] <= update_target;
      r_cnt[w_uidx][w_uway] <= w_cnt_next;
    end else if (w_alloc) begin
      r_valid[w_uidx][w_alloc_way] <= 1'b1;
      r_tag[w_uidx][w_alloc_way]   <= w_utag;
      r_tgt[w_uidx][w_alloc_way]   <= update_target;
      r_cnt[w_uidx][w_alloc_way]   <= CNT_INIT;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed self-checking bench for btb_assoc (SETS=16, WAYS=2).
`default_nettype none

module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        update = 1'b0;
  logic [31:0] update_pc = '0;
  logic [31:0] update_target = '0;
  logic        update_taken = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target_pc;
  logic        valid;
  logic        predictedTaken;

  int n_cmp  = 0;
  int n_fail = 0;

  btb_assoc #(.SETS(16), .WAYS(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .update         (update),
    .update_pc      (update_pc),
    .update_target  (update_target),
    .update_taken   (update_taken),
    .flush          (flush),
    .target_pc      (target_pc),
    .valid          (valid),
    .predictedTaken (predictedTaken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
    update = 1'b1; update_pc = a; update_target = t; update_taken = tk;
    tick();
    update = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a [2];
    logic [31:0] e [2];
    a[0] = 32'h000A0000; e[0] = 32'h000A0004;
    a[1] = 32'hFFFFFFFC; e[1] = 32'h00000000;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, predictedTaken, target_pc} !== {2'b00, e[i]}) begin
        n_fail++;
        $display("FAIL in_reset_%0d: got v=%0b t=%0b pc=%h want v=0 t=0 pc=%h", i, valid, predictedTaken, target_pc, e[i]);
      end
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, predictedTaken, target_pc} !== {2'b00, e[i]}) begin
        n_fail++;
        $display("FAIL after_reset_%0d: got v=%0b t=%0b pc=%h want v=0 t=0 pc=%h", i, valid, predictedTaken, target_pc, e[i]);
      end
    end
  endtask

  task automatic test_alloc();
    do_upd(32'h000A0000, 32'h000A0020, 1'b1);
    pc = 32'h000A0000; #1;
    n_cmp++;
    if ({valid, predictedTaken, target_pc} !== {2'b11, 32'h000A0020}) begin
      n_fail++;
      $display("FAIL alloc_hit: got v=%0b t=%0b pc=%h want v=1 t=1 pc=000a0020", valid, predictedTaken, target_pc);
    end
  endtask

  // Direction sequence from counter 10; expected predictedTaken after each update.
  task automatic test_counter();
    logic tk  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    logic exp [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    pc = 32'h000A0000;
    for (int i = 0; i < 10; i++) begin
      do_upd(32'h000A0000, 32'h000A0020, tk[i]);
      #1;
      n_cmp++;
      if ({valid, predictedTaken, target_pc} !== {1'b1, exp[i], 32'h000A0020}) begin
        n_fail++;
        $display("FAIL counter_step_%0d: got v=%0b t=%0b pc=%h want v=1 t=%0b pc=000a0020", i, valid, predictedTaken, target_pc, exp[i]);
      end
    end
  endtask

  task automatic test_evict();
    logic [31:0] a [4];
    logic [31:0] t [4];
    logic [31:0] e1 [4];
    logic [31:0] e2 [4];
    logic        h1 [4] = '{0, 1, 1, 0};
    logic        h2 [4] = '{0, 0, 1, 1};
    a[0] = 32'h000A0000; t[0] = 32'h000A0020;
    a[1] = 32'h000B0000; t[1] = 32'h000B0040;
    a[2] = 32'h000C0000; t[2] = 32'h000C0060;
    a[3] = 32'h000E0000; t[3] = 32'h000E0080;
    for (int i = 0; i < 4; i++) begin
      e1[i] = h1[i] ? t[i] : a[i] + 32'd4;
      e2[i] = h2[i] ? t[i] : a[i] + 32'd4;
    end
    flush = 1'b1; tick(); flush = 1'b0;
    pc = a[0]; #1;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_miss: got v=%0b want v=0", valid);
    end
    for (int i = 0; i < 3; i++) do_upd(a[i], t[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, predictedTaken, target_pc} !== {h1[i], h1[i], e1[i]}) begin
        n_fail++;
        $display("FAIL evict1_%0d: got v=%0b t=%0b pc=%h want v=%0b t=%0b pc=%h", i, valid, predictedTaken, target_pc, h1[i], h1[i], e1[i]);
      end
    end
    do_upd(a[3], t[3], 1'b1);
    for (int i = 0; i < 4; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, predictedTaken, target_pc} !== {h2[i], h2[i], e2[i]}) begin
        n_fail++;
        $display("FAIL evict2_%0d: got v=%0b t=%0b pc=%h want v=%0b t=%0b pc=%h", i, valid, predictedTaken, target_pc, h2[i], h2[i], e2[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    a[0] = 32'h000D0000; a[1] = 32'h000E0000; a[2] = 32'h000F0000;
    pc = 32'h000D0000;
    update = 1'b1; update_pc = 32'h000D0000; update_target = 32'h000D0100; update_taken = 1'b1;
    #1;
    n_cmp++;
    if ({valid, target_pc} !== {1'b0, 32'h000D0004}) begin
      n_fail++;
      $display("FAIL no_bypass: got v=%0b pc=%h want v=0 pc=000d0004", valid, target_pc);
    end
    tick();
    update = 1'b0; #1;
    n_cmp++;
    if ({valid, predictedTaken, target_pc} !== {2'b11, 32'h000D0100}) begin
      n_fail++;
      $display("FAIL next_cycle_hit: got v=%0b t=%0b pc=%h want v=1 t=1 pc=000d0100", valid, predictedTaken, target_pc);
    end
    flush = 1'b1;
    update = 1'b1; update_pc = 32'h000F0000; update_target = 32'h000F0200; update_taken = 1'b1;
    tick();
    flush = 1'b0; update = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, target_pc} !== {1'b0, a[i] + 32'd4}) begin
        n_fail++;
        $display("FAIL flush_upd_%0d: got v=%0b pc=%h want v=0 pc=%h", i, valid, target_pc, a[i] + 32'd4);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a [4];
    a[0] = 32'h00010004; a[1] = 32'h00010008; a[2] = 32'h0001000C; a[3] = 32'h00010010;
    for (int i = 0; i < 3; i++) do_upd(a[i], 32'h00020000 + 32'(i), 1'b1);
    pc = a[1]; #1;
    n_cmp++;
    if ({valid, target_pc} !== {1'b1, 32'h00020001}) begin
      n_fail++;
      $display("FAIL pre_reset_hit: got v=%0b pc=%h want v=1 pc=00020001", valid, target_pc);
    end
    update = 1'b1; update_pc = a[3]; update_target = 32'h00030000; update_taken = 1'b1;
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, predictedTaken, target_pc} !== {2'b00, a[i] + 32'd4}) begin
        n_fail++;
        $display("FAIL async_reset_%0d: got v=%0b t=%0b pc=%h want v=0 t=0 pc=%h", i, valid, predictedTaken, target_pc, a[i] + 32'd4);
      end
    end
    tick();
    update = 1'b0;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      pc = a[i]; #1;
      n_cmp++;
      if ({valid, target_pc} !== {1'b0, a[i] + 32'd4}) begin
        n_fail++;
        $display("FAIL post_reset_%0d: got v=%0b pc=%h want v=0 pc=%h", i, valid, target_pc, a[i] + 32'd4);
      end
    end
    do_upd(a[0], 32'h00040000, 1'b0);
    pc = a[0]; #1;
    n_cmp++;
    if ({valid, target_pc} !== {1'b0, 32'h00010008}) begin
      n_fail++;
      $display("FAIL nt_no_alloc: got v=%0b pc=%h want v=0 pc=00010008", valid, target_pc);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_evict();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter SETS, default 16, number of sets (power of two, 2..256).
REQ-002 SHALL have parameter WAYS, default 2, ways per set (1, 2 or 4).
REQ-003 SHALL have parameter XLEN, default 32, address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pc  input  XLEN  fetch-stage lookup address.
REQ-007 SHALL have port update  input  1  resolved-branch update strobe.
REQ-008 SHALL have port update_pc  input  XLEN  address of the resolved branch.
REQ-009 SHALL have port update_target  input  XLEN  resolved target.
REQ-010 SHALL have port update_taken  input  1  actual branch outcome.
REQ-011 SHALL have port flush  input  1  invalidate all entries.
REQ-012 SHALL have port target_pc  output  XLEN  predicted next pc.
REQ-013 SHALL have port valid  output  1  lookup hit.
REQ-014 SHALL have port predictedTaken  output  1  hit and counter predicts taken.

Function
REQ-015 SHALL derive index = addr[IDX+1:2] and tag = addr[XLEN-1:IDX+2], with IDX = log2(SETS); this rule SHALL apply to both pc and update_pc.
REQ-016 SHALL give each entry a valid bit, tag, XLEN target and 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 SHALL perform lookup combinationally (zero latency): valid = 1 when any valid way in set index(pc) has a matching tag.
REQ-018 On a hit, target_pc SHALL be the stored target and predictedTaken SHALL be counter[1].
REQ-019 On a miss, valid = 0, predictedTaken = 0 and target_pc = pc + 4, with wrap modulo 2^XLEN.
REQ-020 SHALL make updates visible to lookup on the cycle after the update edge; there SHALL be no same-cycle bypass.
REQ-021 Update hit (update=1, tag match): SHALL write the target, increment the counter if update_taken, decrement it otherwise, saturating at 11 and 00.
REQ-022 Update miss with update_taken=1: SHALL allocate into the lowest-numbered invalid way; if none is invalid, into the way at the set's round-robin pointer. The new entry SHALL get valid=1, tag, target and counter=10.
REQ-023 Update miss with update_taken=0: SHALL make no state change.
REQ-024 Each set's round-robin pointer SHALL advance by 1 (mod WAYS) only on an allocation that replaces a valid way.
REQ-025 SHALL never have more than one way per set matching the same tag; allocation occurs only on a miss.
REQ-026 flush=1 SHALL clear all valid bits and pointers at the next edge; flush SHALL take priority over a simultaneous update, which is dropped.
REQ-027 When WAYS=1, the pointer logic SHALL be absent and allocation SHALL always replace way 0.

Reset
REQ-028 While rst=0, SHALL asynchronously clear all valid bits, set all counters to 01, set all targets to 0 and set all pointers to 0.
REQ-029 During and after reset, outputs SHALL be valid=0, predictedTaken=0, target_pc=pc+4.
REQ-030 Reset asserted mid-update SHALL discard the update.

Structure
REQ-031 Package btb_pkg SHALL hold the counter typedef, the four counter-state constants, CNT_INIT=10 and the index/tag width functions.
REQ-032 SHALL use one sub-module, btb_sat_counter, for the 2-bit saturating next-state logic (inputs cnt, taken; output cnt_next).

Verification
REQ-033 Reset, then pc=0x000A0000 -> valid=0, predictedTaken=0, target_pc=0x000A0004.
REQ-034 Update pc 0x000A0000, target 0x000A0020, taken=1; next-cycle lookup -> valid=1, predictedTaken=1, target_pc=0x000A0020.
REQ-035 Two not-taken updates to 0x000A0000 -> counter 10->01->00, predictedTaken=0 with valid=1; three further not-taken updates -> counter stays at 00.
REQ-036 SETS=16, WAYS=2: allocate 0x000A0000, 0x000B0000 and 0x000C0000 (same index 0) -> 0x000A0000 evicted (pointer 0), others hit; a fourth tag evicts 0x000B0000.
REQ-037 Same-cycle update and lookup of 0x000D0000 -> lookup misses that cycle and hits next cycle; flush together with update -> all lookups miss.
REQ-038 Assert rst mid-run after three allocations -> every lookup misses; update with taken=0 on a miss -> no allocation.
